// File: rtl/wts_key_scheduler_pkg.sv
// Shared command codes and sizing defaults for the key scheduler slice.
// Latency: n/a (declarations only). Backpressure: n/a.
package wts_key_scheduler_pkg;

  typedef enum logic [1:0] {
    CMD_NONE    = 2'd0,
    CMD_ON      = 2'd1,
    CMD_RELEASE = 2'd2,
    CMD_OFF     = 2'd3
  } cmd_e;

  localparam int CH_NUM_DEF        = 5;
  localparam int PRESCALE_BITS_DEF = 12;
  localparam int CH_W              = 3;
  localparam int GATE_W            = 8;

endpackage

// File: rtl/wts_key_gate_timer.sv
// One channel: pending key command, stored gate length and gate down-counter.
// Latency: state updates on the clk edge after issue/tick. Backpressure: none, last write wins.
module wts_key_gate_timer
  import wts_key_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic              wr,
  input  cmd_e              wr_code,
  input  logic [GATE_W-1:0] wr_gate,
  input  logic              issue,
  input  logic              tick,
  output cmd_e              pending,
  output logic              gate_busy
);

  logic [GATE_W-1:0] stored_gate;
  logic [GATE_W-1:0] gate_cnt;
  logic [GATE_W-1:0] cnt_next;
  cmd_e              pend_next;
  logic              auto_rel;

  // An issued key_on reload beats a coincident tick; auto-release only fires on an idle channel.
  always_comb begin
    cnt_next = gate_cnt;
    auto_rel = 1'b0;
    if (issue && pending == CMD_ON) begin
      cnt_next = stored_gate;
    end else if (issue && (pending == CMD_RELEASE || pending == CMD_OFF)) begin
      cnt_next = '0;
    end else if (tick && gate_cnt != '0) begin
      cnt_next = gate_cnt - GATE_W'(1);
      auto_rel = (gate_cnt == GATE_W'(1)) && (pending == CMD_NONE);
    end
  end

  always_comb begin
    pend_next = pending;
    if (wr) begin
      pend_next = wr_code;
    end else if (auto_rel) begin
      pend_next = CMD_RELEASE;
    end else if (issue) begin
      pend_next = CMD_NONE;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pending     <= CMD_NONE;
      stored_gate <= '0;
      gate_cnt    <= '0;
      gate_busy   <= 1'b0;
    end else begin
      pending   <= pend_next;
      gate_cnt  <= cnt_next;
      gate_busy <= (cnt_next != '0);
      if (wr) begin
        stored_gate <= wr_gate;
      end
    end
  end

endmodule

// File: rtl/wts_key_scheduler.sv
// Round-robin key event scheduler: one channel served per active pulse, with gate auto-release.
// Latency: pulses decode combinationally in the active clk. Backpressure: none, host writes always accepted.
module wts_key_scheduler
  import wts_key_scheduler_pkg::*;
#(
  parameter int CH_NUM        = CH_NUM_DEF,
  parameter int PRESCALE_BITS = PRESCALE_BITS_DEF
) (
  input  logic              nreset,
  input  logic              clk,
  input  logic              active,
  input  logic              cmd_valid,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [1:0]        cmd_code,
  input  logic [GATE_W-1:0] cmd_gate,
  output logic [CH_NUM-1:0] key_on,
  output logic [CH_NUM-1:0] key_release,
  output logic [CH_NUM-1:0] key_off,
  output logic [CH_NUM-1:0] gate_busy
);

  localparam logic [CH_W-1:0] SLOT_LAST = CH_W'(CH_NUM - 1);
  localparam logic [CH_W:0]   CH_LIM    = (CH_W + 1)'(CH_NUM);

  logic [CH_W-1:0]          ff_slot;
  logic [PRESCALE_BITS-1:0] ff_presc;
  logic                     tick;
  logic                     cmd_hit;
  cmd_e                     pend [CH_NUM];

  assign cmd_hit = cmd_valid && (cmd_code != 2'd0) && ({1'b0, cmd_ch} < CH_LIM);
  assign tick    = active && (&ff_presc);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ff_slot  <= '0;
      ff_presc <= '0;
    end else if (active) begin
      ff_slot  <= (ff_slot == SLOT_LAST) ? '0 : ff_slot + CH_W'(1);
      ff_presc <= ff_presc + PRESCALE_BITS'(1);
    end
  end

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    wts_key_gate_timer u_gate (
      .clk       (clk),
      .nreset    (nreset),
      .wr        (cmd_hit && (cmd_ch == CH_W'(n))),
      .wr_code   (cmd_e'(cmd_code)),
      .wr_gate   (cmd_gate),
      .issue     (active && (ff_slot == CH_W'(n))),
      .tick      (tick),
      .pending   (pend[n]),
      .gate_busy (gate_busy[n])
    );
  end

  always_comb begin
    key_on      = '0;
    key_release = '0;
    key_off     = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      if (active && (ff_slot == CH_W'(n))) begin
        case (pend[n])
          CMD_ON:      key_on[n]      = 1'b1;
          CMD_RELEASE: key_release[n] = 1'b1;
          CMD_OFF:     key_off[n]     = 1'b1;
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wts_key_scheduler.sv
// Directed bench for wts_key_scheduler with a short prescaler so gate timeouts fit in a few dozen actives.
module tb_wts_key_scheduler;

  logic       nreset;
  logic       clk;
  logic       active;
  logic       cmd_valid;
  logic [2:0] cmd_ch;
  logic [1:0] cmd_code;
  logic [7:0] cmd_gate;
  logic [4:0] key_on;
  logic [4:0] key_release;
  logic [4:0] key_off;
  logic [4:0] gate_busy;

  int n_checks = 0;
  int n_fail   = 0;

  wts_key_scheduler #(.CH_NUM(5), .PRESCALE_BITS(4)) dut (
    .nreset      (nreset),
    .clk         (clk),
    .active      (active),
    .cmd_valid   (cmd_valid),
    .cmd_ch      (cmd_ch),
    .cmd_code    (cmd_code),
    .cmd_gate    (cmd_gate),
    .key_on      (key_on),
    .key_release (key_release),
    .key_off     (key_off),
    .gate_busy   (gate_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    nreset    = 1'b0;
    active    = 1'b0;
    cmd_valid = 1'b0;
    #2;
    check("rst_pulses", 32'({key_on, key_release, key_off}), 32'd0);
    check("rst_busy", 32'(gate_busy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  task automatic write_cmd(input logic [2:0] ch, input logic [1:0] code, input logic [7:0] g);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_code  = code;
    cmd_gate  = g;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // One active clk (optionally with a host write in the same clk), then one idle clk.
  task automatic do_active(input logic v, input logic [2:0] ch, input logic [1:0] code,
                           input logic [7:0] g, output logic [4:0] on, output logic [4:0] rel,
                           output logic [4:0] off, output logic [4:0] busy);
    @(posedge clk);
    #1;
    active    = 1'b1;
    cmd_valid = v;
    cmd_ch    = ch;
    cmd_code  = code;
    cmd_gate  = g;
    @(negedge clk);
    on  = key_on;
    rel = key_release;
    off = key_off;
    @(posedge clk);
    #1;
    active    = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    busy = gate_busy;
    check("idle_quiet", 32'({key_on, key_release, key_off}), 32'd0);
  endtask

  task automatic act(output logic [4:0] on, output logic [4:0] rel,
                     output logic [4:0] off, output logic [4:0] busy);
    do_active(1'b0, 3'd0, 2'd0, 8'd0, on, rel, off, busy);
  endtask

  initial begin
    logic [4:0] on, rel, off, busy, exp;
    nreset    = 1'b0;
    active    = 1'b0;
    cmd_valid = 1'b0;
    cmd_ch    = '0;
    cmd_code  = '0;
    cmd_gate  = '0;

    // ch2 key_on with no gate: one pulse at slot 2, never busy
    do_reset();
    write_cmd(3'd2, 2'd1, 8'd0);
    for (int k = 0; k < 10; k++) begin
      act(on, rel, off, busy);
      check("s1_on", 32'(on), (k == 2) ? 32'h4 : 32'h0);
      check("s1_rel_off", 32'({rel, off}), 32'd0);
      check("s1_busy", 32'(busy), 32'd0);
    end

    // key_on overwritten by key_off before service
    do_reset();
    write_cmd(3'd0, 2'd1, 8'd5);
    write_cmd(3'd0, 2'd3, 8'd0);
    for (int k = 0; k < 6; k++) begin
      act(on, rel, off, busy);
      check("s2_on", 32'(on), 32'd0);
      check("s2_off", 32'(off), (k == 0) ? 32'h1 : 32'h0);
      check("s2_rel", 32'(rel), 32'd0);
      check("s2_busy", 32'(busy), 32'd0);
    end

    // gate=3 on ch1: ticks at actives 15/31/47, release at next slot-1 active (51)
    do_reset();
    write_cmd(3'd1, 2'd1, 8'd3);
    for (int k = 0; k < 61; k++) begin
      act(on, rel, off, busy);
      check("s3_on", 32'(on), (k == 1) ? 32'h2 : 32'h0);
      check("s3_rel", 32'(rel), (k == 51) ? 32'h2 : 32'h0);
      check("s3_off", 32'(off), 32'd0);
      check("s3_busy", 32'(busy), (k >= 1 && k < 47) ? 32'h2 : 32'h0);
    end

    // write to ch3 in the clk ch3 is issued: old command now, new one a full round later
    do_reset();
    write_cmd(3'd3, 2'd1, 8'd0);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) do_active(1'b1, 3'd3, 2'd3, 8'd0, on, rel, off, busy);
      else        act(on, rel, off, busy);
      check("s4_on", 32'(on), (k == 3) ? 32'h8 : 32'h0);
      check("s4_off", 32'(off), (k == 8) ? 32'h8 : 32'h0);
      check("s4_rel", 32'(rel), 32'd0);
    end

    // burst key_on to every channel, one write per clk
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_ch    = 3'(c);
      cmd_code  = 2'd1;
      cmd_gate  = 8'd0;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      act(on, rel, off, busy);
      exp = (k < 5) ? 5'(1 << k) : 5'd0;
      check("s5_on", 32'(on), 32'(exp));
      check("s5_rel_off", 32'({rel, off}), 32'd0);
    end

    // reset during a running gate of 2, with a key_off about to issue
    do_reset();
    write_cmd(3'd0, 2'd1, 8'd2);
    act(on, rel, off, busy);
    check("s6_on", 32'(on), 32'h1);
    check("s6_busy", 32'(busy), 32'h1);
    for (int k = 1; k < 4; k++) act(on, rel, off, busy);
    write_cmd(3'd4, 2'd3, 8'd0);
    @(posedge clk);
    #1;
    active = 1'b1;
    #1;
    check("s6_pre_off", 32'(key_off), 32'h10);
    nreset = 1'b0;
    #1;
    check("s6_rst_pulses", 32'({key_on, key_release, key_off}), 32'd0);
    check("s6_rst_busy", 32'(gate_busy), 32'd0);
    @(posedge clk);
    #1;
    active = 1'b0;
    @(posedge clk);
    #1;
    nreset = 1'b1;
    for (int k = 0; k < 60; k++) begin
      act(on, rel, off, busy);
      check("s6_after_pulses", 32'({on, rel, off}), 32'd0);
      check("s6_after_busy", 32'(busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
